// File: rtl/aes_subbyte_seq.sv
// Time-multiplexed AES SubBytes / InvSubBytes engine: LANES S-boxes sweep the
// 128-bit state in 16/LANES passes behind valid/ready handshakes.

package aes_gf_pkg;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

module aes_sboxb (
  input  logic [7:0] di,
  output logic [7:0] do2
);
  import aes_gf_pkg::*;
  logic [7:0] b;

  always_comb begin
    b   = gf_inv(di);
    do2 = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_sboxb (
  input  logic [7:0] di,
  output logic [7:0] do2
);
  import aes_gf_pkg::*;
  logic [7:0] a;

  always_comb begin
    a   = {di[6:0], di[7]} ^ {di[4:0], di[7:5]} ^ {di[1:0], di[7:2]} ^ 8'h05;
    do2 = gf_inv(a);
  end
endmodule

module aes_subbyte_seq #(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned PASSES = 16 / LANES;
  localparam int unsigned CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned LW     = 8 * LANES;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_subbyte_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           inv_q;
  logic [127:0]   work;
  logic [6:0]     off;
  logic           last;
  logic [LW-1:0]  lane_in;
  logic [LW-1:0]  lane_fwd;
  logic [LW-1:0]  lane_inv;
  logic [LW-1:0]  lane_out;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  always_comb begin
    off      = 7'(32'(cnt) * LW);
    last     = (cnt == CW'(PASSES - 1));
    lane_in  = work[off +: LW];
    lane_out = inv_q ? lane_inv : lane_fwd;
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    aes_sboxb u_fwd (.di(lane_in[8*l +: 8]), .do2(lane_fwd[8*l +: 8]));
    if (INV_EN) begin : g_inv
      aes_inv_sboxb u_inv (.di(lane_in[8*l +: 8]), .do2(lane_inv[8*l +: 8]));
    end else begin : g_no_inv
      assign lane_inv[8*l +: 8] = lane_fwd[8*l +: 8];
    end
  end

  // Control FSM with registered outputs; accept in DONE overlaps the output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      inv_q     <= 1'b0;
      work      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            inv_q <= in_inv & INV_EN;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          out_data[off +: LW] <= lane_out;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_data;
              inv_q <= in_inv & INV_EN;
              cnt   <= '0;
              state <= RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
